alu_sliced_seq: RTL and testbench

Parametrised, multi-cycle bit-sliced ALU: a WIDTH-bit operation runs through one SLICE-bit slice per clock, least-significant slice first, with the inter-slice carry held in a register. It keeps the four-bit-slice function set (mode `m`, select `s`, carry-in `cin`). It trades latency for area in datapaths wider than the combinational ripple ALU can close timing on. A start/busy/done handshake lets a controller FSM sequence it.

---
 rtl/alu_sliced_seq.sv | 139 +++++++++++++
 tb/tb_alu_sliced_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_sliced_seq.sv
// alu_sliced_seq: multi-cycle bit-sliced ALU, one SLICE-bit slice per clock, LSB slice first.
// Define ALU_FLAGS_EN to add the registered zero/neg/ovf result flags.
module alu_sliced_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic [3:0]       s,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);
  localparam int N = WIDTH / SLICE;
  localparam int KW = $clog2(N + 1);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;

  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_chk
    $error("alu_sliced_seq: WIDTH must be a nonzero multiple of SLICE");
  end

  logic [0:0]       st;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] ra, rb, o_nx;
  logic             rm, c, last, cim;
  logic [3:0]       rs;
  logic [SLICE-1:0] sa, sb, x, y, lf, f;
  logic [SLICE:0]   sum;

  assign busy = (st == RUN);
  assign sa = ra[SLICE-1:0];
  assign sb = rb[SLICE-1:0];

  always_comb begin
    case (rs)
      4'd0:  lf = ~sa;
      4'd1:  lf = ~(sa | sb);
      4'd2:  lf = ~sa & sb;
      4'd3:  lf = '0;
      4'd4:  lf = ~(sa & sb);
      4'd5:  lf = ~sb;
      4'd6:  lf = sa ^ sb;
      4'd7:  lf = sa & ~sb;
      4'd8:  lf = ~sa | sb;
      4'd9:  lf = ~(sa ^ sb);
      4'd10: lf = sb;
      4'd11: lf = sa & sb;
      4'd12: lf = '1;
      4'd13: lf = sa | ~sb;
      4'd14: lf = sa | sb;
      default: lf = sa;
    endcase
    case (rs)
      4'd0:  {x, y} = {sa, {SLICE{1'b0}}};
      4'd1:  {x, y} = {sa | sb, {SLICE{1'b0}}};
      4'd2:  {x, y} = {sa | ~sb, {SLICE{1'b0}}};
      4'd3:  {x, y} = {{SLICE{1'b0}}, {SLICE{1'b1}}};
      4'd4:  {x, y} = {sa, sa & ~sb};
      4'd5:  {x, y} = {sa | sb, sa & ~sb};
      4'd6:  {x, y} = {sa, ~sb};
      4'd7:  {x, y} = {sa & ~sb, {SLICE{1'b1}}};
      4'd8:  {x, y} = {sa, sa & sb};
      4'd9:  {x, y} = {sa, sb};
      4'd10: {x, y} = {sa | ~sb, sa & sb};
      4'd11: {x, y} = {sa & sb, {SLICE{1'b1}}};
      4'd12: {x, y} = {sa, sa};
      4'd13: {x, y} = {sa | sb, sa};
      4'd14: {x, y} = {sa | ~sb, sa};
      default: {x, y} = {sa, {SLICE{1'b1}}};
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
    f = rm ? lf : sum[SLICE-1:0];
    cim = x[SLICE-1] ^ y[SLICE-1] ^ sum[SLICE-1];
    // Result slices enter at the top and shift down, so slice 0 lands at the LSB after N cycles.
    o_nx = (o >> SLICE) | (WIDTH'(f) << (WIDTH - SLICE));
    last = (k == KW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      k <= '0;
      ra <= '0;
      rb <= '0;
      rm <= 1'b0;
      rs <= '0;
      c <= 1'b0;
      done <= 1'b0;
      o <= '0;
      cout <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero <= 1'b0;
      neg <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (st == IDLE) begin
        if (start) begin
          st <= RUN;
          ra <= a;
          rb <= b;
          rm <= m;
          rs <= s;
          c <= cin & ~m;
          k <= '0;
        end
      end else begin
        o <= o_nx;
        ra <= ra >> SLICE;
        rb <= rb >> SLICE;
        c <= ~rm & sum[SLICE];
        k <= k + 1'b1;
        if (last) begin
          st <= IDLE;
          done <= 1'b1;
          cout <= ~rm & sum[SLICE];
`ifdef ALU_FLAGS_EN
          zero <= (o_nx == '0);
          neg <= o_nx[WIDTH-1];
          ovf <= ~rm & (cim ^ sum[SLICE]);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_sliced_seq.sv
// tb_alu_sliced_seq: directed + randomized checks of alu_sliced_seq against a full-width reference model.
module tb_alu_sliced_seq;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, m = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0, o;
  logic [3:0]  s = '0;
  logic        busy, done, cout;
  int checks = 0, errors = 0;
  logic [15:0] r_o;
  logic        r_cout;
  logic [17:0] exp_v;
`ifdef ALU_FLAGS_EN
  logic zero, neg, ovf;
`endif

  alu_sliced_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m), .s(s), .cin(cin),
    .busy(busy), .done(done), .o(o), .cout(cout)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .neg(neg), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Returns {ovf, cout, result} computed on the whole word at once.
  function automatic logic [17:0] model(logic [15:0] fa, logic [15:0] fb, logic fm, logic [3:0] fs, logic fc);
    logic [15:0] x, y, r;
    logic [16:0] sum;
    logic [15:0] lo;
    if (fm) begin
      case (fs)
        0: r = ~fa;          1: r = ~(fa | fb);  2: r = ~fa & fb;    3: r = 16'h0000;
        4: r = ~(fa & fb);   5: r = ~fb;         6: r = fa ^ fb;     7: r = fa & ~fb;
        8: r = ~fa | fb;     9: r = ~(fa ^ fb);  10: r = fb;         11: r = fa & fb;
        12: r = 16'hFFFF;    13: r = fa | ~fb;   14: r = fa | fb;    default: r = fa;
      endcase
      return {2'b00, r};
    end
    case (fs)
      0: begin x = fa; y = 0; end                 1: begin x = fa | fb; y = 0; end
      2: begin x = fa | ~fb; y = 0; end           3: begin x = 0; y = 16'hFFFF; end
      4: begin x = fa; y = fa & ~fb; end          5: begin x = fa | fb; y = fa & ~fb; end
      6: begin x = fa; y = ~fb; end               7: begin x = fa & ~fb; y = 16'hFFFF; end
      8: begin x = fa; y = fa & fb; end           9: begin x = fa; y = fb; end
      10: begin x = fa | ~fb; y = fa & fb; end    11: begin x = fa & fb; y = 16'hFFFF; end
      12: begin x = fa; y = fa; end               13: begin x = fa | fb; y = fa; end
      14: begin x = fa | ~fb; y = fa; end         default: begin x = fa; y = 16'hFFFF; end
    endcase
    sum = {1'b0, x} + {1'b0, y} + 17'(fc);
    lo = {1'b0, x[14:0]} + {1'b0, y[14:0]} + 16'(fc);
    return {lo[15] ^ sum[16], sum};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(string tag);
    int lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_o"}, o, exp_v[15:0]);
    chk({tag, "_cout"}, cout, exp_v[16]);
    chk({tag, "_busy_at_done"}, busy, 0);
`ifdef ALU_FLAGS_EN
    chk({tag, "_zero"}, zero, exp_v[15:0] == 16'h0);
    chk({tag, "_neg"}, neg, exp_v[15]);
    chk({tag, "_ovf"}, ovf, exp_v[17]);
`endif
    r_o = o;
    r_cout = cout;
  endtask

  // Called at a negedge; ends at the negedge where done is high.
  task automatic run_op(string tag, logic [15:0] ta, logic [15:0] tb, logic tm, logic [3:0] ts, logic tc);
    a = ta; b = tb; m = tm; s = ts; cin = tc; start = 1'b1;
    exp_v = model(ta, tb, tm, ts, tc);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_o", o, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 16'h1234, 16'h0FF0, 0, 9, 0);
    chk("add_const", {r_cout, r_o}, {1'b0, 16'h2224});
    run_op("sub", 16'h1234, 16'h0FF0, 0, 6, 1);
    chk("sub_const", {r_cout, r_o}, {1'b1, 16'h0244});
    run_op("xor", 16'h1234, 16'h0FF0, 1, 6, 1);
    chk("xor_const", {r_cout, r_o}, {1'b0, 16'h1DC4});
    run_op("ripple", 16'hFFFF, 16'h0001, 0, 9, 0);
    chk("ripple_const", {r_cout, r_o}, {1'b1, 16'h0000});
    run_op("ovf", 16'h7FFF, 16'h0001, 0, 9, 0);
    chk("ovf_const", {r_cout, r_o}, {1'b0, 16'h8000});

    // start kept high through busy with junk operands, then the done cycle carries op2
    a = 16'hA5A5; b = 16'h0F0F; m = 0; s = 9; cin = 1; start = 1'b1;
    exp_v = model(16'hA5A5, 16'h0F0F, 0, 9, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("hs_busy", busy, 1);
      a = 16'($urandom); b = 16'($urandom); m = 1'($urandom); s = 4'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    chk("hs_done", done, 1);
    chk("hs_first_o", o, exp_v[15:0]);
    chk("hs_first_cout", cout, exp_v[16]);
    a = 16'h8001; b = 16'h7FFF; m = 0; s = 6; cin = 1;
    exp_v = model(16'h8001, 16'h7FFF, 0, 6, 1);
    @(negedge clk);
    start = 1'b0;
    chk("hs_done_drop", done, 0);
    chk("hs_second_busy", busy, 1);
    wait_done("hs_second");

    // reset after E2 of an operation
    a = 16'hFFFF; b = 16'hFFFF; m = 1; s = 12; cin = 0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_o", o, 0);
    chk("midrst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 16'h4321, 16'h1111, 0, 9, 1);

    for (int i = 0; i < 40; i++)
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
